sd_cmd_sequencer: RTL and testbench

//  Upstream command stage for the SPI byte engine (spi_controller). Accepts one SD command (index + 32-bit arg),

---
 rtl/sd_cmd_sequencer_pkg.sv | 40 ++++
 rtl/sd_cmd_sequencer_if.sv | 25 ++
 rtl/sd_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared types and helpers for the SD command sequencer: FSM states, SD command
// indices, engine op encoding and the CRC7 used to seal every command frame.
package sd_cmd_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEND_W,
        ST_POLL,
        ST_POLL_W,
        ST_EXT,
        ST_EXT_W,
        ST_TRAIL,
        ST_TRAIL_W,
        ST_RESP
    } state_t;

    localparam logic [5:0] SD_CMD_CMD0   = 6'd0;
    localparam logic [5:0] SD_CMD_CMD8   = 6'd8;
    localparam logic [5:0] SD_CMD_CMD55  = 6'd55;
    localparam logic [5:0] SD_CMD_ACMD41 = 6'd41;
    localparam logic [5:0] SD_CMD_CMD58  = 6'd58;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // x^7 + x^3 + 1, zero init, MSB first over the first five frame bytes.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = d[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return crc;
    endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Command request / response bundle between an SD init or block layer (master)
// and the command sequencer (slave).
interface sd_cmd_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        cmd_ext;
    logic        rsp_valid;
    logic [7:0]  rsp_r1;
    logic [31:0] rsp_ext;
    logic        rsp_timeout;

    modport master (
        output cmd_valid, cmd_idx, cmd_arg, cmd_ext,
        input  cmd_ready, rsp_valid, rsp_r1, rsp_ext, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_idx, cmd_arg, cmd_ext,
        output cmd_ready, rsp_valid, rsp_r1, rsp_ext, rsp_timeout
    );

endinterface

// File: rtl/sd_cmd_sequencer.sv
// Frames one SD command, pushes it through the SPI byte engine, polls for R1,
// optionally collects the R3/R7 tail, clocks a trailer byte and reports.
module sd_cmd_sequencer
    import sd_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int NCR_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_cmd_sequencer_if.slave cmd,
    output logic              cs_n,
    output logic              spi_start,
    output logic              spi_op,
    output logic [ADDR_W-1:0] spi_size,
    input  logic [ADDR_W-1:0] spi_address,
    output logic [7:0]        spi_data_in,
    input  logic [7:0]        spi_data_out,
    input  logic              spi_wr,
    input  logic              spi_done
);

    localparam logic [7:0]        NCR_LIMIT = 8'(NCR_MAX);
    localparam logic [ADDR_W-1:0] SIZE_CMD  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] SIZE_EXT  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] SIZE_ONE  = '0;

    state_t          state;
    logic [5:0][7:0] frame;
    logic            ext_q;
    logic [7:0]      poll_cnt;
    logic [7:0]      poll_byte;
    logic [6:0]      crc_now;
    logic [7:0]      r1_now;

    assign crc_now = crc7({2'b01, cmd.cmd_idx, cmd.cmd_arg});
    // A byte strobed in the same cycle as done must still be seen as the poll result.
    assign r1_now  = spi_wr ? spi_data_out : poll_byte;

    always_comb begin
        spi_data_in = 8'hFF;
        if (spi_address < ADDR_W'(6)) spi_data_in = frame[spi_address[2:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cmd.cmd_ready   <= 1'b1;
            cs_n            <= 1'b1;
            spi_start       <= 1'b0;
            spi_op          <= OP_READ;
            spi_size        <= '0;
            cmd.rsp_valid   <= 1'b0;
            cmd.rsp_r1      <= 8'hFF;
            cmd.rsp_ext     <= '0;
            cmd.rsp_timeout <= 1'b0;
            poll_cnt        <= '0;
            poll_byte       <= 8'hFF;
            frame           <= '0;
            ext_q           <= 1'b0;
        end else begin
            spi_start     <= 1'b0;
            cmd.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        frame <= {{crc_now, 1'b1},
                                  cmd.cmd_arg[7:0], cmd.cmd_arg[15:8],
                                  cmd.cmd_arg[23:16], cmd.cmd_arg[31:24],
                                  {2'b01, cmd.cmd_idx}};
                        ext_q           <= cmd.cmd_ext;
                        poll_cnt        <= '0;
                        cmd.rsp_r1      <= 8'hFF;
                        cmd.rsp_ext     <= '0;
                        cmd.rsp_timeout <= 1'b0;
                        cmd.cmd_ready   <= 1'b0;
                        cs_n            <= 1'b0;
                        state           <= ST_SEND;
                        spi_start       <= 1'b1;
                        spi_op          <= OP_WRITE;
                        spi_size        <= SIZE_CMD;
                    end
                end
                ST_SEND: state <= ST_SEND_W;
                ST_SEND_W: begin
                    if (spi_done) begin
                        state     <= ST_POLL;
                        spi_start <= 1'b1;
                        spi_op    <= OP_READ;
                        spi_size  <= SIZE_ONE;
                    end
                end
                ST_POLL: state <= ST_POLL_W;
                ST_POLL_W: begin
                    if (spi_wr) poll_byte <= spi_data_out;
                    if (spi_done) begin
                        spi_start <= 1'b1;
                        spi_op    <= OP_READ;
                        spi_size  <= SIZE_ONE;
                        if (!r1_now[7]) begin
                            cmd.rsp_r1 <= r1_now;
                            if (ext_q) begin
                                state    <= ST_EXT;
                                spi_size <= SIZE_EXT;
                            end else begin
                                state <= ST_TRAIL;
                            end
                        end else if (poll_cnt + 8'd1 == NCR_LIMIT) begin
                            poll_cnt        <= poll_cnt + 8'd1;
                            cmd.rsp_timeout <= 1'b1;
                            cmd.rsp_r1      <= 8'hFF;
                            state           <= ST_TRAIL;
                        end else begin
                            poll_cnt <= poll_cnt + 8'd1;
                            state    <= ST_POLL;
                        end
                    end
                end
                ST_EXT: state <= ST_EXT_W;
                ST_EXT_W: begin
                    // Engine byte 0 lands in the top byte: index (3 - addr) == ~addr.
                    if (spi_wr) cmd.rsp_ext[{~spi_address[1:0], 3'b000} +: 8] <= spi_data_out;
                    if (spi_done) begin
                        state     <= ST_TRAIL;
                        spi_start <= 1'b1;
                        spi_op    <= OP_READ;
                        spi_size  <= SIZE_ONE;
                    end
                end
                ST_TRAIL: state <= ST_TRAIL_W;
                ST_TRAIL_W: begin
                    if (spi_done) begin
                        state         <= ST_RESP;
                        cmd.rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    cs_n          <= 1'b1;
                    cmd.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: a behavioural SPI byte engine plus SD card
// responder, with expected frames/responses scoreboarded against what the DUT emits.
module tb_sd_cmd_sequencer;
    import sd_cmd_sequencer_pkg::*;

    localparam int ADDR_W  = 6;
    localparam int NCR_MAX = 8;

    typedef struct packed {
        logic [7:0]  r1;
        logic [31:0] ext;
        logic        timeout;
    } rsp_t;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] size;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_cmd_sequencer_if cmd_bus();

    logic              cs_n, spi_start, spi_op;
    logic [ADDR_W-1:0] spi_size, spi_address;
    logic [7:0]        spi_data_in, spi_data_out;
    logic              spi_wr, spi_done;

    sd_cmd_sequencer #(.ADDR_W(ADDR_W), .NCR_MAX(NCR_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_bus), .cs_n(cs_n),
        .spi_start(spi_start), .spi_op(spi_op), .spi_size(spi_size),
        .spi_address(spi_address), .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out), .spi_wr(spi_wr), .spi_done(spi_done)
    );

    rsp_t       exp_rsp_q[$];
    rsp_t       obs_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] mosi_q[$];
    logic [7:0] card_q[$];
    xfer_t      xfer_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int rsp_count = 0;
    int accept_count = 0;
    int byte_count = 0;
    int cs_run = 0;
    int last_gap = 0;

    // Engine model: 8 SCLK clocks per byte, wr strobe per byte, done after the last.
    logic              eng_busy, eng_op;
    logic [ADDR_W-1:0] eng_size;
    int                eng_bit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_busy <= 1'b0; eng_op <= 1'b0; eng_size <= '0; eng_bit <= 0;
            spi_wr <= 1'b0; spi_done <= 1'b0; spi_address <= '0; spi_data_out <= 8'hFF;
        end else begin
            spi_wr   <= 1'b0;
            spi_done <= 1'b0;
            if (!eng_busy) begin
                if (spi_start) begin
                    eng_busy <= 1'b1; eng_op <= spi_op; eng_size <= spi_size;
                    spi_address <= '0; eng_bit <= 0;
                    xfer_q.push_back('{op: spi_op, size: spi_size});
                end
            end else if (eng_bit < 7) begin
                eng_bit <= eng_bit + 1;
            end else if (eng_bit == 7) begin
                eng_bit    <= 8;
                spi_wr     <= 1'b1;
                byte_count <= byte_count + 1;
                if (eng_op) begin
                    mosi_q.push_back(spi_data_in);
                    spi_data_out <= 8'hFF;
                end else if (card_q.size() > 0) begin
                    spi_data_out <= card_q.pop_front();
                end else begin
                    spi_data_out <= 8'hFF;
                end
            end else if (spi_address == eng_size) begin
                spi_done <= 1'b1;
                eng_busy <= 1'b0;
            end else begin
                spi_address <= spi_address + 1'b1;
                eng_bit     <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmd_bus.rsp_valid) begin
            obs_q.push_back('{r1: cmd_bus.rsp_r1, ext: cmd_bus.rsp_ext, timeout: cmd_bus.rsp_timeout});
            rsp_count++;
        end
        if (cs_n) cs_run++;
        else begin
            if (cs_run > 0) last_gap = cs_run;
            cs_run = 0;
        end
    end

    always @(posedge clk) begin
        if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) accept_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic ext,
                                 input logic [7:0] crc_byte, input rsp_t exp);
        int t = 0;
        exp_tx_q.push_back({2'b01, idx});
        exp_tx_q.push_back(arg[31:24]);
        exp_tx_q.push_back(arg[23:16]);
        exp_tx_q.push_back(arg[15:8]);
        exp_tx_q.push_back(arg[7:0]);
        exp_tx_q.push_back(crc_byte);
        exp_rsp_q.push_back(exp);
        while (!cmd_bus.cmd_ready && t < 2000) begin @(negedge clk); t++; end
        checkOutput("ready_before_cmd", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        cmd_bus.cmd_idx   = idx;
        cmd_bus.cmd_arg   = arg;
        cmd_bus.cmd_ext   = ext;
        cmd_bus.cmd_valid = 1'b1;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic collectResponse(input string tag);
        rsp_t o, e;
        int   t = 0;
        while (obs_q.size() == 0 && t < 5000) begin @(negedge clk); t++; end
        if (obs_q.size() == 0 || exp_rsp_q.size() == 0) begin
            checkOutput({tag, "_rsp_seen"}, 32'd0, 32'd1);
            return;
        end
        o = obs_q.pop_front();
        e = exp_rsp_q.pop_front();
        checkOutput({tag, "_r1"}, {24'd0, o.r1}, {24'd0, e.r1});
        checkOutput({tag, "_ext"}, o.ext, e.ext);
        checkOutput({tag, "_timeout"}, {31'd0, o.timeout}, {31'd0, e.timeout});
    endtask

    task automatic checkFrame(input string tag);
        int n = exp_tx_q.size();
        for (int i = 0; i < n; i++) begin
            if (mosi_q.size() == 0) checkOutput({tag, "_mosi_missing"}, 32'd0, 32'd1);
            else checkOutput({tag, "_mosi"}, {24'd0, mosi_q.pop_front()}, {24'd0, exp_tx_q.pop_front()});
        end
        exp_tx_q.delete();
        checkOutput({tag, "_mosi_extra"}, mosi_q.size(), 32'd0);
    endtask

    function automatic int countXfers(input logic op, input logic [ADDR_W-1:0] size);
        int c = 0;
        foreach (xfer_q[i]) if (xfer_q[i].op == op && xfer_q[i].size == size) c++;
        return c;
    endfunction

    initial begin
        int b0, r0, a0, t;
        bit seen_first;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_idx   = '0;
        cmd_bus.cmd_arg   = '0;
        cmd_bus.cmd_ext   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        checkOutput("rst_cs_n", {31'd0, cs_n}, 32'd1);
        checkOutput("rst_start", {31'd0, spi_start}, 32'd0);
        checkOutput("rst_op", {31'd0, spi_op}, 32'd0);
        checkOutput("rst_size", {26'd0, spi_size}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, cmd_bus.rsp_valid}, 32'd0);
        checkOutput("rst_r1", {24'd0, cmd_bus.rsp_r1}, 32'h0000_00FF);
        checkOutput("rst_ext", cmd_bus.rsp_ext, 32'd0);
        checkOutput("rst_timeout", {31'd0, cmd_bus.rsp_timeout}, 32'd0);
        checkOutput("rst_frame0", {24'd0, spi_data_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] test 1: CMD0");
        xfer_q.delete(); b0 = byte_count;
        card_q = '{8'hFF, 8'hFF, 8'h01};
        applyStimulus(SD_CMD_CMD0, 32'h0, 1'b0, 8'h95, '{r1: 8'h01, ext: 32'h0, timeout: 1'b0});
        collectResponse("t1");
        checkFrame("t1");
        checkOutput("t1_first_write", countXfers(OP_WRITE, ADDR_W'(5)), 32'd1);
        checkOutput("t1_single_reads", countXfers(OP_READ, '0), 32'd4);
        checkOutput("t1_bytes", byte_count - b0, 32'd10);
        repeat (5) @(negedge clk);
        checkOutput("t1_hold_r1", {24'd0, cmd_bus.rsp_r1}, 32'h01);
        checkOutput("t1_cs_idle", {31'd0, cs_n}, 32'd1);

        $display("[TB] test 2: CMD8 with R7 tail");
        xfer_q.delete();
        card_q = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        applyStimulus(SD_CMD_CMD8, 32'h0000_01AA, 1'b1, 8'h87, '{r1: 8'h01, ext: 32'h0000_01AA, timeout: 1'b0});
        collectResponse("t2");
        checkFrame("t2");
        checkOutput("t2_ext_xfers", countXfers(OP_READ, ADDR_W'(3)), 32'd1);

        $display("[TB] test 3: silent card");
        xfer_q.delete(); b0 = byte_count;
        applyStimulus(SD_CMD_CMD58, 32'h0, 1'b1, 8'hFD, '{r1: 8'hFF, ext: 32'h0, timeout: 1'b1});
        collectResponse("t3");
        checkFrame("t3");
        checkOutput("t3_single_reads", countXfers(OP_READ, '0), 32'd9);
        checkOutput("t3_ext_xfers", countXfers(OP_READ, ADDR_W'(3)), 32'd0);
        checkOutput("t3_bytes", byte_count - b0, 32'd15);

        $display("[TB] test 4: cmd_valid held high");
        r0 = rsp_count; a0 = accept_count;
        card_q = '{8'h01, 8'hFF, 8'h01, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            exp_tx_q.push_back(8'h40);
            repeat (4) exp_tx_q.push_back(8'h00);
            exp_tx_q.push_back(8'h95);
            exp_rsp_q.push_back('{r1: 8'h01, ext: 32'h0, timeout: 1'b0});
        end
        cmd_bus.cmd_idx = SD_CMD_CMD0; cmd_bus.cmd_arg = '0; cmd_bus.cmd_ext = 1'b0;
        cmd_bus.cmd_valid = 1'b1;
        t = 0; seen_first = 1'b0;
        while (t < 5000) begin
            @(negedge clk); t++;
            if (cmd_bus.rsp_valid) begin
                if (seen_first) break;
                seen_first = 1'b1;
                checkOutput("t4_accepts_at_rsp1", accept_count - a0, 32'd1);
            end
        end
        cmd_bus.cmd_valid = 1'b0;
        checkOutput("t4_done_in_time", {31'd0, (t < 5000)}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("t4_accepts", accept_count - a0, 32'd2);
        checkOutput("t4_cs_gap", {31'd0, (last_gap >= 1)}, 32'd1);
        collectResponse("t4a");
        collectResponse("t4b");
        checkFrame("t4");
        checkOutput("t4_rsp_pulses", rsp_count - r0, 32'd2);

        $display("[TB] test 5: reset during command write");
        r0 = rsp_count;
        applyStimulus(SD_CMD_CMD0, 32'h0, 1'b0, 8'h95, '{r1: 8'h01, ext: 32'h0, timeout: 1'b0});
        t = 0;
        while (!(eng_busy && eng_op && spi_address == ADDR_W'(3) && eng_bit == 2) && t < 2000) begin
            @(negedge clk); t++;
        end
        checkOutput("t5_reached_byte3", {31'd0, (t < 2000)}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_cs_n", {31'd0, cs_n}, 32'd1);
        checkOutput("t5_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        exp_tx_q.delete(); exp_rsp_q.delete(); mosi_q.delete(); card_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t5_no_rsp", rsp_count - r0, 32'd0);
        checkOutput("t5_cs_n_after", {31'd0, cs_n}, 32'd1);
        card_q = '{8'hFF, 8'hFF, 8'h01};
        applyStimulus(SD_CMD_CMD0, 32'h0, 1'b0, 8'h95, '{r1: 8'h01, ext: 32'h0, timeout: 1'b0});
        collectResponse("t5b");
        checkFrame("t5b");

        $display("[TB] test 6: R1 on the last allowed poll");
        xfer_q.delete(); b0 = byte_count;
        card_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        applyStimulus(SD_CMD_CMD55, 32'h0, 1'b0, 8'h65, '{r1: 8'h00, ext: 32'h0, timeout: 1'b0});
        collectResponse("t6");
        checkFrame("t6");
        checkOutput("t6_sclk", (byte_count - b0) * 8, 32'd120);
        checkOutput("t6_single_reads", countXfers(OP_READ, '0), 32'd9);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
